fetch_stepper: RTL and testbench
================================

// Module: fetch_stepper
// PURPOSE
//   Stepper/sequencer for the 8-bit CPU instruction cycle.
//   Drives the IAR, MAR, ACC, RAM and IR bus-enable/set strobes for fetch steps 1-3.
//   Hands steps 4-6 to the execute decoder through a one-hot step vector.
//   Provides run/halt control and a stop-address breakpoint on the IAR value, read directly from the IAR.
// PARAMETERS
//   ADDR_W  8   width of IAR value / stop address
//   CNT_W   16  width of retired-instruction counter
// PORTS
//   clk        in   1       system clock, rising edge
//   reset_n    in   1       synchronous, active-low reset
//   run        in   1       start (from IDLE) / resume (from HALTED), level-sampled
//   halt_req   in   1       request halt at next instruction boundary
//   exec_done  in   1       execute decoder: instruction complete early (valid in S4/S5)
//   stop_en    in   1       enable stop-address breakpoint
//   stop_addr  in   ADDR_W  breakpoint address
//   iar_value  in   ADDR_W  direct IAR contents
//   BUS1       out  1       force bus to 1 for the ALU increment
//   OIAR       out  1       IAR drives cpu_bus
//   IIAR       out  1       IAR loads from cpu_bus
//   IMAR       out  1       MAR loads from cpu_bus
//   IACC       out  1       ACC loads from ALU
//   OACC       out  1       ACC drives cpu_bus
//   ORAM       out  1       RAM drives cpu_bus
//   IIR        out  1       IR loads from cpu_bus
//   step       out  6       one-hot current step; bit0=S1 ... bit5=S6; 0 in IDLE/HALTED
//   running    out  1       1 in S1..S6
//   halted     out  1       1 in HALTED
//   retired    out  CNT_W   count of completed instructions, wraps to 0
// BEHAVIOUR
//   Reset is synchronous and active-low: reset_n=0 at a rising clk edge -> state IDLE, retired=0.
//   All outputs are 0 from the following cycle. This holds from any state, including mid-instruction.
//   States: IDLE, S1..S6, HALTED. The state register is binary. All outputs are Moore-decoded from the state register only.
//   Strobes per state (all others 0):
//     S1 = OIAR, BUS1, IMAR, IACC
//     S2 = ORAM, IIR
//     S3 = OACC, IIAR
//     S4..S6 = no strobes, step only
//   IDLE: run=1 -> S1; otherwise stay. halt_req is ignored in IDLE.
//   S1->S2->S3->S4 unconditionally. exec_done is ignored in S1..S3.
//   S4/S5: exec_done=1 -> boundary. Otherwise go to the next step. S6 -> boundary always; exec_done in S6 is don't-care.
//   Boundary (end of instruction), evaluated on the S4/S5/S6 exit edge:
//     retired += 1 (wraps from 2^CNT_W-1 to 0).
//     If halt_req=1, or (stop_en=1 and iar_value==stop_addr) -> HALTED; else -> S1.
//     halt_req and breakpoint together -> HALTED, a single transition.
//   HALTED: run=1 -> S1. The breakpoint is not rechecked on resume, so execution continues past stop_addr.
//   Simultaneous run and halt_req in HALTED -> S1. Any pending halt is then honoured at the next boundary.
//   Latency:
//     run sampled at edge k -> S1 strobes during cycle k+1.
//     A full instruction takes 6 cycles; the shortest (exec_done in S4) takes 4.
//   Exactly one of IDLE/HALTED/step-bit is active per cycle. OIAR and IIAR are never high together.
//     At most one bus driver (OIAR/ORAM/OACC) is high in any cycle.
// TESTING
//   1. Reset, then run=1 for 1 cycle
//      -> cycles 1..6 step=000001,000010,...,100000.
//      -> OIAR/BUS1/IMAR/IACC=1 only in cycle 1; ORAM/IIR only in cycle 2; OACC/IIAR only in cycle 3.
//      -> S1 again in cycle 7; retired=1.
//   2. exec_done=1 during S4
//      -> next cycle is S1; retired increments; S5/S6 never appear.
//   3. stop_en=1, stop_addr=8'h05, iar_value=8'h05 at the S6 exit
//      -> HALTED, halted=1, all strobes 0.
//      -> run=1 -> S1 next cycle, with no re-halt while iar_value still equals 8'h05.
//   4. halt_req pulsed during S2
//      -> the instruction completes through S6, then HALTED.
//      -> halt_req held in IDLE with run=1 -> S1.
//   5. reset_n=0 during S3
//      -> next cycle IDLE, all outputs 0, retired=0.
//      -> reset_n=1 with run=0 -> stays in IDLE.
//   6. Preload-free wrap check with CNT_W=4: 16 instructions with exec_done in S4
//      -> retired sequence reaches 15, then 0.

Source files
------------

// File: rtl/fetch_stepper.sv
// fetch_stepper: instruction-cycle sequencer driving fetch strobes S1-S3, one-hot steps S4-S6,
// run/halt control with a latched halt request and an IAR stop-address breakpoint.
module fetch_stepper #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run,
    input  logic              halt_req,
    input  logic              exec_done,
    input  logic              stop_en,
    input  logic [ADDR_W-1:0] stop_addr,
    input  logic [ADDR_W-1:0] iar_value,
    output logic              BUS1,
    output logic              OIAR,
    output logic              IIAR,
    output logic              IMAR,
    output logic              IACC,
    output logic              OACC,
    output logic              ORAM,
    output logic              IIR,
    output logic [5:0]        step,
    output logic              running,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);
    typedef enum logic [2:0] {IDLE, S1, S2, S3, S4, S5, S6, HALTED} state_t;
    state_t state;
    logic halt_pend, at_end, stop;
    always_comb begin
        at_end = state == S6 || ((state == S4 || state == S5) && exec_done);
        stop   = halt_req || halt_pend || (stop_en && iar_value == stop_addr);
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            retired   <= '0;
            halt_pend <= 1'b0;
        end else begin
            if (at_end) retired <= retired + 1'b1;
            case (state)
                IDLE, HALTED: state <= run ? S1 : state;
                S1:           state <= S2;
                S2:           state <= S3;
                S3:           state <= S4;
                default:      state <= at_end ? (stop ? HALTED : S1) : state_t'(state + 3'd1);
            endcase
            // a halt requested mid-instruction is held until the boundary consumes it
            halt_pend <= (at_end || state == IDLE) ? 1'b0 :
                         (state == HALTED) ? (run && halt_req) : (halt_pend || halt_req);
        end
    end
    always_comb begin
        step    = {state == S6, state == S5, state == S4, state == S3, state == S2, state == S1};
        running = step != 6'd0;
        halted  = state == HALTED;
        OIAR    = state == S1;
        BUS1    = state == S1;
        IMAR    = state == S1;
        IACC    = state == S1;
        ORAM    = state == S2;
        IIR     = state == S2;
        OACC    = state == S3;
        IIAR    = state == S3;
    end
endmodule

// File: tb/tb_fetch_stepper.sv
// tb_fetch_stepper: table-driven directed vectors plus hand sequences for halt, breakpoint and counter wrap.
module tb_fetch_stepper;
    logic clk = 1'b0;
    logic reset_n, run, halt_req, exec_done, stop_en;
    logic [7:0] stop_addr, iar_value;
    logic BUS1, OIAR, IIAR, IMAR, IACC, OACC, ORAM, IIR, running, halted;
    logic [5:0] step;
    logic [15:0] retired;
    logic BUS1_4, OIAR_4, IIAR_4, IMAR_4, IACC_4, OACC_4, ORAM_4, IIR_4, running_4, halted_4;
    logic [5:0] step_4;
    logic [3:0] retired_4;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fetch_stepper dut (
        .clk(clk), .reset_n(reset_n), .run(run), .halt_req(halt_req), .exec_done(exec_done),
        .stop_en(stop_en), .stop_addr(stop_addr), .iar_value(iar_value),
        .BUS1(BUS1), .OIAR(OIAR), .IIAR(IIAR), .IMAR(IMAR), .IACC(IACC), .OACC(OACC),
        .ORAM(ORAM), .IIR(IIR), .step(step), .running(running), .halted(halted), .retired(retired)
    );

    fetch_stepper #(.ADDR_W(8), .CNT_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .run(run), .halt_req(halt_req), .exec_done(exec_done),
        .stop_en(stop_en), .stop_addr(stop_addr), .iar_value(iar_value),
        .BUS1(BUS1_4), .OIAR(OIAR_4), .IIAR(IIAR_4), .IMAR(IMAR_4), .IACC(IACC_4), .OACC(OACC_4),
        .ORAM(ORAM_4), .IIR(IIR_4), .step(step_4), .running(running_4), .halted(halted_4),
        .retired(retired_4)
    );

    localparam logic [5:0] I = 6'd0, P1 = 6'd1, P2 = 6'd2, P3 = 6'd4, P4 = 6'd8, P5 = 6'd16, P6 = 6'd32;

    typedef struct {
        logic rst_n, run, hreq, edone, sen;
        logic [7:0] iar;
        logic [5:0] st;
        logic hlt;
        logic [15:0] ret;
    } vec_t;

    vec_t vecs[45];

    function automatic vec_t mk(logic r, logic ru, logic h, logic e, logic s, logic [7:0] ia,
                                logic [5:0] st, logic hl, logic [15:0] rt);
        vec_t v;
        v.rst_n = r; v.run = ru; v.hreq = h; v.edone = e; v.sen = s;
        v.iar = ia; v.st = st; v.hlt = hl; v.ret = rt;
        return v;
    endfunction

    // strobe order: BUS1 OIAR IIAR IMAR IACC OACC ORAM IIR
    function automatic logic [7:0] exp_strb(logic [5:0] st);
        return st[0] ? 8'b1101_1000 : st[1] ? 8'b0000_0011 : st[2] ? 8'b0010_0100 : 8'h00;
    endfunction

    task automatic drive(logic r, logic ru, logic h, logic e, logic s, logic [7:0] ia);
        reset_n = r; run = ru; halt_req = h; exec_done = e; stop_en = s; iar_value = ia;
        @(posedge clk);
        #1;
    endtask

    task automatic check(string nm, logic [5:0] st, logic hl, logic [15:0] rt);
        logic [32:0] got, exp;
        got = {step, BUS1, OIAR, IIAR, IMAR, IACC, OACC, ORAM, IIR, halted, running, retired};
        exp = {st, exp_strb(st), hl, st != 6'd0, rt};
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got step=%b strb=%b halted=%b running=%b retired=%0d, want step=%b strb=%b halted=%b running=%b retired=%0d",
                     nm, got[32:27], got[26:19], got[18], got[17], got[15:0],
                     exp[32:27], exp[26:19], exp[18], exp[17], exp[15:0]);
        end
        n_chk++;
        if ($countones(step) + int'(halted) > 1 || (OIAR && IIAR) || int'(OIAR) + int'(ORAM) + int'(OACC) > 1) begin
            n_fail++;
            $display("FAIL %s invariant: step=%b halted=%b OIAR=%b IIAR=%b ORAM=%b OACC=%b, want exclusive",
                     nm, step, halted, OIAR, IIAR, ORAM, OACC);
        end
    endtask

    initial begin
        stop_addr = 8'h05;
        reset_n = 0; run = 0; halt_req = 0; exec_done = 0; stop_en = 0; iar_value = 0;
        // rst_n run hreq edone sen iar -> step halted retired
        vecs[0]  = mk(0,0,0,0,0,8'h00, I, 0,0);
        vecs[1]  = mk(1,1,0,0,0,8'h00, P1,0,0);
        vecs[2]  = mk(1,0,0,0,0,8'h00, P2,0,0);
        vecs[3]  = mk(1,0,0,0,0,8'h00, P3,0,0);
        vecs[4]  = mk(1,0,0,0,0,8'h00, P4,0,0);
        vecs[5]  = mk(1,0,0,0,0,8'h00, P5,0,0);
        vecs[6]  = mk(1,0,0,0,0,8'h00, P6,0,0);
        vecs[7]  = mk(1,0,0,0,0,8'h00, P1,0,1);
        vecs[8]  = mk(1,0,0,1,0,8'h00, P2,0,1);
        vecs[9]  = mk(1,0,0,1,0,8'h00, P3,0,1);
        vecs[10] = mk(1,0,0,1,0,8'h00, P4,0,1);
        vecs[11] = mk(1,0,0,1,0,8'h00, P1,0,2);
        vecs[12] = mk(1,0,0,0,0,8'h00, P2,0,2);
        vecs[13] = mk(1,0,0,0,0,8'h00, P3,0,2);
        vecs[14] = mk(1,0,0,0,0,8'h00, P4,0,2);
        vecs[15] = mk(1,0,0,0,0,8'h00, P5,0,2);
        vecs[16] = mk(1,0,0,1,0,8'h00, P1,0,3);
        vecs[17] = mk(1,0,0,0,0,8'h00, P2,0,3);
        vecs[18] = mk(1,0,0,0,0,8'h00, P3,0,3);
        vecs[19] = mk(1,0,0,0,0,8'h00, P4,0,3);
        vecs[20] = mk(1,0,0,0,0,8'h00, P5,0,3);
        vecs[21] = mk(1,0,0,0,0,8'h00, P6,0,3);
        vecs[22] = mk(1,0,0,0,1,8'h05, I, 1,4);
        vecs[23] = mk(1,0,0,0,1,8'h05, I, 1,4);
        vecs[24] = mk(1,1,0,0,1,8'h05, P1,0,4);
        vecs[25] = mk(1,0,0,0,1,8'h00, P2,0,4);
        vecs[26] = mk(1,0,0,0,1,8'h00, P3,0,4);
        vecs[27] = mk(1,0,0,0,1,8'h00, P4,0,4);
        vecs[28] = mk(1,0,0,0,1,8'h00, P5,0,4);
        vecs[29] = mk(1,0,0,0,1,8'h00, P6,0,4);
        vecs[30] = mk(1,0,0,0,1,8'h00, P1,0,5);
        vecs[31] = mk(1,0,0,0,0,8'h00, P2,0,5);
        vecs[32] = mk(1,0,1,0,0,8'h00, P3,0,5);
        vecs[33] = mk(1,0,0,0,0,8'h00, P4,0,5);
        vecs[34] = mk(1,0,0,0,0,8'h00, P5,0,5);
        vecs[35] = mk(1,0,0,0,0,8'h00, P6,0,5);
        vecs[36] = mk(1,0,0,0,0,8'h00, I, 1,6);
        vecs[37] = mk(0,0,0,0,0,8'h00, I, 0,0);
        vecs[38] = mk(1,0,1,0,0,8'h00, I, 0,0);
        vecs[39] = mk(1,1,1,0,0,8'h00, P1,0,0);
        vecs[40] = mk(1,0,0,0,0,8'h00, P2,0,0);
        vecs[41] = mk(1,0,0,0,0,8'h00, P3,0,0);
        vecs[42] = mk(0,0,0,0,0,8'h00, I, 0,0);
        vecs[43] = mk(1,0,0,0,0,8'h00, I, 0,0);
        vecs[44] = mk(1,0,0,0,0,8'h00, I, 0,0);
        for (int i = 0; i < 45; i++) begin
            drive(vecs[i].rst_n, vecs[i].run, vecs[i].hreq, vecs[i].edone, vecs[i].sen, vecs[i].iar);
            check($sformatf("vec%0d", i), vecs[i].st, vecs[i].hlt, vecs[i].ret);
        end

        // halt_req at a short-instruction boundary, then resume with run+halt_req together
        drive(1,1,0,0,0,8'h00); check("hs_s1", P1,0,0);
        drive(1,0,0,0,0,8'h00); check("hs_s2", P2,0,0);
        drive(1,0,0,0,0,8'h00); check("hs_s3", P3,0,0);
        drive(1,0,0,0,0,8'h00); check("hs_s4", P4,0,0);
        drive(1,0,1,1,0,8'h00); check("hs_halt", I,1,1);
        drive(1,1,1,0,0,8'h00); check("hs_resume", P1,0,1);
        drive(1,0,0,0,0,8'h00); check("hs_r2", P2,0,1);
        drive(1,0,0,0,0,8'h00); check("hs_r3", P3,0,1);
        drive(1,0,0,0,0,8'h00); check("hs_r4", P4,0,1);
        drive(1,0,0,1,0,8'h00); check("hs_pending_halt", I,1,2);
        // halt_req and breakpoint together: one transition to HALTED
        drive(1,1,0,0,0,8'h00); check("hb_s1", P1,0,2);
        drive(1,0,0,0,0,8'h00); check("hb_s2", P2,0,2);
        drive(1,0,0,0,0,8'h00); check("hb_s3", P3,0,2);
        drive(1,0,0,0,0,8'h00); check("hb_s4", P4,0,2);
        drive(1,0,1,1,1,8'h05); check("hb_halt", I,1,3);
        drive(1,0,0,0,0,8'h00); check("hb_stay", I,1,3);

        // counter wrap on the CNT_W=4 instance with 4-cycle instructions
        drive(0,0,0,0,0,8'h00); check("wrap_rst", I,0,0);
        drive(1,1,0,0,0,8'h00); check("wrap_s1", P1,0,0);
        for (int k = 1; k <= 16; k++) begin
            drive(1,0,0,0,0,8'h00);
            drive(1,0,0,0,0,8'h00);
            drive(1,0,0,0,0,8'h00);
            drive(1,0,0,1,0,8'h00);
            check($sformatf("wrap_k%0d", k), P1,0,16'(k));
            n_chk++;
            if (retired_4 !== 4'(k % 16)) begin
                n_fail++;
                $display("FAIL wrap4_k%0d: got retired=%0d, want %0d", k, retired_4, k % 16);
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
